// File: rtl/sarray_store_drain_pkg.sv
// Shared definitions for the systolic-array store drain: FSM encodings, default row stride
// and the layout of one buffered result row.
package sarray_store_drain_pkg;

   localparam int STORE_ROW_SHIFT   = 8;
   localparam int STORE_CNT_WIDTH   = 6;
   localparam int STORE_DATA_WIDTH  = 512;

   typedef enum logic [1:0] {
      STORE_ST_IDLE  = 2'd0,
      STORE_ST_DRAIN = 2'd1,
      STORE_ST_FIN   = 2'd2
   } store_st_e;

   typedef struct packed {
      logic [STORE_CNT_WIDTH-1:0]  cnt;
      logic [STORE_DATA_WIDTH-1:0] data;
   } store_entry_t;

endpackage

// File: rtl/sarray_store_fifo.sv
// Synchronous row buffer: head is read combinationally, a push becomes visible one cycle later,
// and a pop frees a slot for a push in the same cycle.
module sarray_store_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_pop_s, do_push_s;

   assign empty_o   = (count_q == {CW{1'b0}});
   assign full_o    = (count_q == CW'(DEPTH));
   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);
   assign rdata_o   = mem_q[head_q];

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (do_pop_s) begin
         head_d = head_q + PW'(1);
      end else begin
         head_d = head_q;
      end
      if (do_push_s) begin
         tail_d = tail_q + PW'(1);
      end else begin
         tail_d = tail_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= {PW{1'b0}};
         tail_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: validity is tracked entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[tail_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/sarray_store_drain.sv
// Captures result rows leaving the array bottom and drains them to memory, one programmed
// store command at a time; address of each row = base + (row cnt << ROW_SHIFT).
module sarray_store_drain
   import sarray_store_drain_pkg::*;
#(
   parameter int ADDR_WIDTH  = 64,
   parameter int STORE_WIDTH = 512,
   parameter int CNT_WIDTH   = 6,
   parameter int FIFO_DEPTH  = 8,
   parameter int ROW_SHIFT   = STORE_ROW_SHIFT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_valid_i,
   output logic                   cfg_ready_o,
   input  logic [ADDR_WIDTH-1:0]  cfg_addr_i,
   input  logic [CNT_WIDTH:0]     cfg_rows_i,
   input  logic                   bot_valid_i,
   input  logic [CNT_WIDTH-1:0]   bot_cnt_i,
   input  logic [STORE_WIDTH-1:0] bot_data_i,
   output logic                   aw_valid_o,
   input  logic                   aw_ready_i,
   output logic [ADDR_WIDTH-1:0]  aw_addr_o,
   output logic [STORE_WIDTH-1:0] aw_data_o,
   output logic                   done_o,
   output logic                   busy_o,
   output logic                   err_ovf_o
);

   localparam int EW = CNT_WIDTH + STORE_WIDTH;

   store_st_e               state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [CNT_WIDTH:0]      rows_q, rows_d, issued_q, issued_d;
   logic                    err_q, err_d;
   logic [EW-1:0]           head_s;
   logic [CNT_WIDTH-1:0]    head_cnt_s;
   logic                    full_s, empty_s, hs_s;

   sarray_store_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bot_valid_i),
      .pop_i   (hs_s),
      .wdata_i ({bot_cnt_i, bot_data_i}),
      .rdata_o (head_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   assign head_cnt_s  = head_s[STORE_WIDTH +: CNT_WIDTH];
   assign aw_data_o   = head_s[STORE_WIDTH-1:0];
   assign aw_addr_o   = base_q + (ADDR_WIDTH'(head_cnt_s) << ROW_SHIFT);
   assign aw_valid_o  = (state_q == STORE_ST_DRAIN) & ~empty_s;
   assign hs_s        = aw_valid_o & aw_ready_i;
   assign cfg_ready_o = (state_q == STORE_ST_IDLE);
   assign busy_o      = (state_q != STORE_ST_IDLE);
   assign done_o      = (state_q == STORE_ST_FIN);
   assign err_ovf_o   = err_q;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      rows_d   = rows_q;
      issued_d = issued_q;
      // A drop only happens when the full FIFO is not popped in the same cycle.
      err_d    = err_q | (bot_valid_i & full_s & ~hs_s);
      case (state_q)
         STORE_ST_IDLE: begin
            if (cfg_valid_i) begin
               base_d   = cfg_addr_i;
               rows_d   = cfg_rows_i;
               issued_d = {(CNT_WIDTH+1){1'b0}};
               state_d  = (cfg_rows_i == {(CNT_WIDTH+1){1'b0}}) ? STORE_ST_FIN : STORE_ST_DRAIN;
            end else begin
               state_d = STORE_ST_IDLE;
            end
         end
         STORE_ST_DRAIN: begin
            if (hs_s) begin
               issued_d = issued_q + (CNT_WIDTH+1)'(1);
               state_d  = (issued_q == rows_q - (CNT_WIDTH+1)'(1)) ? STORE_ST_FIN : STORE_ST_DRAIN;
            end else begin
               state_d = STORE_ST_DRAIN;
            end
         end
         STORE_ST_FIN: state_d = STORE_ST_IDLE;
         default:      state_d = STORE_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= STORE_ST_IDLE;
         base_q   <= {ADDR_WIDTH{1'b0}};
         rows_q   <= {(CNT_WIDTH+1){1'b0}};
         issued_q <= {(CNT_WIDTH+1){1'b0}};
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         rows_q   <= rows_d;
         issued_q <= issued_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_sarray_store_drain.sv
// Randomized and directed bench for sarray_store_drain against a queue-based behavioural model.
module tb_sarray_store_drain;

   localparam int M_IDLE  = 0;
   localparam int M_DRAIN = 1;
   localparam int M_FIN   = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cfg_valid_i = 1'b0;
   logic         cfg_ready_o;
   logic [63:0]  cfg_addr_i = 64'd0;
   logic [6:0]   cfg_rows_i = 7'd0;
   logic         bot_valid_i = 1'b0;
   logic [5:0]   bot_cnt_i = 6'd0;
   logic [511:0] bot_data_i = 512'd0;
   logic         aw_valid_o;
   logic         aw_ready_i = 1'b0;
   logic [63:0]  aw_addr_o;
   logic [511:0] aw_data_o;
   logic         done_o, busy_o, err_ovf_o;

   sarray_store_drain dut (
      .clk(clk), .rst(rst),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_addr_i(cfg_addr_i), .cfg_rows_i(cfg_rows_i),
      .bot_valid_i(bot_valid_i), .bot_cnt_i(bot_cnt_i), .bot_data_i(bot_data_i),
      .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
      .aw_addr_o(aw_addr_o), .aw_data_o(aw_data_o),
      .done_o(done_o), .busy_o(busy_o), .err_ovf_o(err_ovf_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]   cnt;
      logic [511:0] data;
   } row_t;

   row_t        q[$];
   int          m_mode = M_IDLE;
   logic [63:0] m_base = 64'd0;
   int          m_rem = 0;
   bit          m_err = 1'b0;
   bit          m_valid = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   logic [63:0] aw_log[$];

   task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // One clock cycle: check outputs, drive inputs, advance the model to the next edge.
   task automatic cyc(input bit r, input bit cv, input logic [63:0] ca, input logic [6:0] cr,
                      input bit bv, input logic [5:0] bc, input bit ar);
      logic [511:0] bd;
      bit           pop, full, hv;
      int           old_mode;
      @(negedge clk);
      if (m_valid) begin
         hv = (m_mode == M_DRAIN) && (q.size() > 0);
         check_val("cfg_ready", cfg_ready_o, m_mode == M_IDLE);
         check_val("busy", busy_o, m_mode != M_IDLE);
         check_val("done", done_o, m_mode == M_FIN);
         check_val("err_ovf", err_ovf_o, m_err);
         check_val("aw_valid", aw_valid_o, hv);
         if (hv) begin
            check_val("aw_addr", aw_addr_o, m_base + ({58'd0, q[0].cnt} << 8));
            check_val("aw_data", aw_data_o, q[0].data);
         end
      end
      if (aw_valid_o === 1'b1 && ar) aw_log.push_back(aw_addr_o);
      if (done_o === 1'b1) done_cnt++;
      bd = rand512();
      rst = r; cfg_valid_i = cv; cfg_addr_i = ca; cfg_rows_i = cr;
      bot_valid_i = bv; bot_cnt_i = bc; bot_data_i = bd; aw_ready_i = ar;
      if (r) begin
         q.delete();
         m_mode = M_IDLE; m_err = 1'b0; m_valid = 1'b1;
      end else if (m_valid) begin
         pop = (m_mode == M_DRAIN) && (q.size() > 0) && ar;
         full = (q.size() == 8);
         old_mode = m_mode;
         if (pop) begin
            void'(q.pop_front());
            m_rem--;
         end
         if (bv) begin
            if (full && !pop) m_err = 1'b1;
            else q.push_back('{bc, bd});
         end
         case (old_mode)
            M_IDLE:  if (cv) begin
                        m_base = ca; m_rem = int'(cr);
                        m_mode = (cr == 7'd0) ? M_FIN : M_DRAIN;
                     end
            M_DRAIN: if (pop && m_rem == 0) m_mode = M_FIN;
            default: m_mode = M_IDLE;
         endcase
      end
   endtask

   task automatic idle(input int n, input bit ar);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 64'd0, 7'd0, 1'b0, 6'd0, ar);
   endtask

   task automatic clear_logs();
      aw_log.delete();
      done_cnt = 0;
   endtask

   initial begin
      // 1: reset
      cyc(1'b1, 1'b0, 64'd0, 7'd0, 1'b0, 6'd0, 1'b0);
      cyc(1'b1, 1'b0, 64'd0, 7'd0, 1'b0, 6'd0, 1'b0);
      idle(1, 1'b0);
      check_val("rst_cfg_ready", cfg_ready_o, 512'd1);
      check_val("rst_aw_valid", aw_valid_o, 512'd0);
      check_val("rst_done", done_o, 512'd0);
      check_val("rst_err", err_ovf_o, 512'd0);

      // 2: four rows, always ready
      clear_logs();
      cyc(1'b0, 1'b1, 64'h1000, 7'd4, 1'b1, 6'd0, 1'b1);
      for (int k = 1; k < 4; k++) cyc(1'b0, 1'b0, 64'd0, 7'd0, 1'b1, 6'(k), 1'b1);
      idle(8, 1'b1);
      check_val("t2_nwrites", aw_log.size(), 512'd4);
      for (int k = 0; k < 4 && k < aw_log.size(); k++)
         check_val("t2_addr", aw_log[k], 64'h1000 + 64'(k) * 64'h100);
      check_val("t2_done_cnt", done_cnt, 512'd1);

      // 3: same with a five-cycle stall mid-stream
      clear_logs();
      for (int k = 0; k < 16; k++) begin
         cyc(1'b0, k == 0, 64'h1000, 7'd4, k < 4, 6'(k), !(k >= 2 && k < 7));
      end
      check_val("t3_nwrites", aw_log.size(), 512'd4);
      for (int k = 0; k < 4 && k < aw_log.size(); k++)
         check_val("t3_addr", aw_log[k], 64'h1000 + 64'(k) * 64'h100);
      check_val("t3_done_cnt", done_cnt, 512'd1);

      // 4: zero-row command
      clear_logs();
      cyc(1'b0, 1'b1, 64'h5000, 7'd0, 1'b0, 6'd0, 1'b1);
      idle(1, 1'b1);
      check_val("t4_done_now", done_o, 512'd1);
      idle(3, 1'b1);
      check_val("t4_nwrites", aw_log.size(), 512'd0);
      check_val("t4_done_cnt", done_cnt, 512'd1);

      // 5: overflow before any command, then drain eight rows
      clear_logs();
      for (int k = 0; k < 9; k++) cyc(1'b0, 1'b0, 64'd0, 7'd0, 1'b1, 6'(k), 1'b0);
      idle(1, 1'b0);
      check_val("t5_err", err_ovf_o, 512'd1);
      cyc(1'b0, 1'b1, 64'h2000, 7'd8, 1'b0, 6'd0, 1'b1);
      idle(14, 1'b1);
      check_val("t5_nwrites", aw_log.size(), 512'd8);
      for (int k = 0; k < 8 && k < aw_log.size(); k++)
         check_val("t5_addr", aw_log[k], 64'h2000 + 64'(k) * 64'h100);
      check_val("t5_done_cnt", done_cnt, 512'd1);

      // 6: reset after two writes aborts the command
      cyc(1'b1, 1'b0, 64'd0, 7'd0, 1'b0, 6'd0, 1'b0);
      clear_logs();
      cyc(1'b0, 1'b1, 64'h3000, 7'd4, 1'b1, 6'd0, 1'b1);
      for (int k = 1; k < 12 && aw_log.size() < 2; k++)
         cyc(1'b0, 1'b0, 64'd0, 7'd0, k < 4, 6'(k), 1'b1);
      check_val("t6_two_writes", aw_log.size(), 512'd2);
      cyc(1'b1, 1'b0, 64'd0, 7'd0, 1'b0, 6'd0, 1'b0);
      idle(1, 1'b1);
      check_val("t6_aw_valid", aw_valid_o, 512'd0);
      check_val("t6_idle", cfg_ready_o, 512'd1);
      cyc(1'b0, 1'b1, 64'h4000, 7'd1, 1'b0, 6'd0, 1'b1);
      idle(3, 1'b1);
      check_val("t6_fifo_empty", aw_log.size(), 512'd2);
      check_val("t6_no_done", done_cnt, 512'd0);

      // Random traffic
      cyc(1'b1, 1'b0, 64'd0, 7'd0, 1'b0, 6'd0, 1'b0);
      for (int k = 0; k < 400; k++) begin
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
             {$urandom, $urandom}, 7'($urandom_range(0, 10)),
             $urandom_range(0, 1) == 1, 6'($urandom), $urandom_range(0, 3) != 0);
      end
      idle(1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
